dac_spi_tx: RTL

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dds_pkg.sv | 46 ++++
 rtl/dac_clk_div.sv | 37 +++
 rtl/dac_spi_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module : dds_pkg
// Brief  : Frame layout, SCLK half-period constants and FSM states for the DAC link.
// Rev    : 1.0
// ============================================================================
package dds_pkg;

    localparam int DAC_DW = 16;
    localparam int H_FAST = 2;
    localparam int H_SLOW = 4;
    localparam int HW     = 3;

    localparam int PWR_MSB  = 15;
    localparam int PWR_LSB  = 14;
    localparam int PAD_MSB  = 13;
    localparam int PAD_LSB  = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_END   = 3'd3,
        S_GAP   = 3'd4
    } dac_state_e;

    // Power field on top, two zero pad bits, then the 12 most significant sample bits.
    function automatic logic [DAC_DW-1:0] build_frame(input logic [1:0]        pwr,
                                                      input logic [DATA_W-1:0] data);
        logic [DAC_DW-1:0] f;
        f                    = '0;
        f[PWR_MSB:PWR_LSB]   = pwr;
        f[PAD_MSB:PAD_LSB]   = 2'b00;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

    function automatic logic [HW-1:0] half_period(input logic fast);
        return fast ? HW'(H_FAST) : HW'(H_SLOW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_clk_div.sv
`default_nettype none
// ============================================================================
// Module : dac_clk_div
// Brief  : Loadable half-period counter; tick_o marks the last cycle of each phase.
// Rev    : 1.0
// ============================================================================
module dac_clk_div
    import dds_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [HW-1:0] half_i,
    input  logic          run_i,
    output logic          tick_o
);

    logic [HW-1:0] half_q;
    logic [HW-1:0] cnt_q;

    // The half-period is latched at load so it cannot change mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            half_q <= HW'(H_SLOW);
            cnt_q  <= '0;
        end else if (load_i) begin
            half_q <= half_i;
            cnt_q  <= half_i - HW'(1);
        end else if (run_i) begin
            cnt_q  <= (cnt_q == '0) ? (half_q - HW'(1)) : (cnt_q - HW'(1));
        end
    end

    assign tick_o = run_i && !load_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module : dac_spi_tx
// Brief  : Serialises 16-bit DAC frames (power field + 12 sample MSBs) over SPI.
// Rev    : 1.0
// ============================================================================
module dac_spi_tx
    import dds_pkg::*;
#(
    parameter int SW = 16,
    parameter int DW = DAC_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [SW-1:0] sample,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          speed_sel,
    input  logic [1:0]    power_state,
    output logic          dac_sclk,
    output logic          dac_mosi,
    output logic          dac_csb,
    output logic          frame_done
);

    localparam int BW = $clog2(DW);

    dac_state_e    state_q, state_d;
    logic [DW-1:0] frame_q, frame_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          csb_q, csb_d;
    logic          done_q, done_d;

    logic          w_ready;
    logic          w_accept;
    logic          w_tick;
    logic          w_run;
    logic [HW-1:0] w_half;
    logic          w_unused_lsbs;

    assign w_ready       = (state_q == S_IDLE) && en && !rst;
    assign w_accept      = w_ready && sample_valid;
    assign w_run         = (state_q != S_IDLE);
    assign w_half        = half_period(speed_sel);
    assign w_unused_lsbs = ^sample[SW-DATA_W-1:0];

    dac_clk_div u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_accept),
        .half_i (w_half),
        .run_i  (w_run),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csb_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csb_q   <= csb_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic computes the pin values for the following cycle, so
    // every DAC pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csb_d   = csb_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                if (w_accept) begin
                    state_d = S_SETUP;
                    frame_d = DW'(build_frame(power_state, sample[SW-1 -: DATA_W]));
                    bit_d   = BW'(DW - 1);
                    csb_d   = 1'b0;
                    mosi_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    mosi_d  = frame_q[bit_q];
                end
            end
            S_SHIFT: begin
                // MOSI moves only with the rising edge, leaving it settled
                // for the whole low phase in which the DAC samples.
                if (w_tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == '0) begin
                        state_d = S_END;
                    end else begin
                        bit_d  = bit_q - BW'(1);
                        sclk_d = 1'b1;
                        mosi_d = frame_q[bit_q - BW'(1)];
                    end
                end
            end
            S_END: begin
                if (w_tick) begin
                    state_d = S_GAP;
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign sample_ready = w_ready;
    assign dac_sclk     = sclk_q;
    assign dac_mosi     = mosi_q;
    assign dac_csb      = csb_q;
    assign frame_done   = done_q;

endmodule
`default_nettype wire
